spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl_if.sv | 10 +
 rtl/spi_reg_ctrl.sv | 154 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// SPI pin bundle between a controller (master) and the register block (slave).
// All three lines are asynchronous to the register block's system clock.
interface spi_reg_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 write-only register block: 16-bit frames (R/W, 7-bit address, data)
// oversampled in the clk domain, committed into a small bank of control registers.
module spi_reg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic              clk,
    input  logic              rst,
    spi_reg_ctrl_if.slave     spi,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              frame_err
);

    localparam int         REG_SLOTS  = (NUM_REGS > 5) ? NUM_REGS : 5;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);
    localparam int         LAST       = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_hist_q;
    logic                   copi_hist_q;
    logic                   ncs_hist_q;
    logic [SYNC_STAGES:0]   settle_q;
    logic                   armed_q;

    state_t                 state_q;
    logic [15:0]            shift_q;
    logic [4:0]             cnt_q;
    logic                   frame_err_q;
    logic [7:0]             regs_q [REG_SLOTS];

    logic                   sclk_rise_s;
    logic                   ncs_rise_s;
    logic                   ncs_fall_s;
    logic                   write_s;

    // Input synchronizers, edge-history flops and post-reset arming.
    // Arming waits until the chain holds only post-reset samples and ncs is seen
    // high, so a frame cut by reset cannot restart on the flops' reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            copi_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
            sclk_hist_q <= sclk_sync_q[LAST];
            copi_hist_q <= copi_sync_q[LAST];
            ncs_hist_q  <= ncs_sync_q[LAST];
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            if (settle_q[SYNC_STAGES] && ncs_sync_q[LAST]) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Edge detection and frame decode.
    always_comb begin
        sclk_rise_s = 1'b0;
        ncs_rise_s  = 1'b0;
        ncs_fall_s  = 1'b0;
        write_s     = 1'b0;
        sclk_rise_s = sclk_sync_q[LAST] & ~sclk_hist_q;
        ncs_rise_s  = ncs_sync_q[LAST] & ~ncs_hist_q;
        ncs_fall_s  = armed_q & ncs_hist_q & ~ncs_sync_q[LAST];
        if ((cnt_q == 5'd16) && shift_q[15] && ({1'b0, shift_q[14:8]} < NUM_REGS_L)) begin
            write_s = 1'b1;
        end else begin
            write_s = 1'b0;
        end
    end

    // Frame FSM, shift register, bit counter, register bank and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= 16'h0000;
            cnt_q       <= 5'd0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < REG_SLOTS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall_s) begin
                        state_q <= SHIFT;
                        shift_q <= 16'h0000;
                        cnt_q   <= 5'd0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise_s) begin
                        shift_q <= {shift_q[14:0], copi_hist_q};
                        if (cnt_q != 5'd17) begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    if (ncs_rise_s) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (cnt_q != 5'd16) begin
                        frame_err_q <= 1'b1;
                    end
                    for (int i = 0; i < REG_SLOTS; i++) begin
                        if (write_s && (shift_q[14:8] == 7'(i))) begin
                            regs_q[i] <= shift_q[7:0];
                        end
                    end
                    // A new select arriving during commit starts the next frame directly.
                    if (ncs_fall_s) begin
                        state_q <= SHIFT;
                        shift_q <= 16'h0000;
                        cnt_q   <= 5'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives SPI mode-0 frames through the pin
// interface and compares the register outputs against hand-computed values.
module tb_spi_reg_ctrl;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    int         err_pulses = 0;
    logic [7:0] exp_r [5];
    logic [7:0] obs   [5];

    spi_reg_ctrl_if spi_bus ();

    spi_reg_ctrl #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi_bus),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    assign obs[0] = en_reg_out_7_0;
    assign obs[1] = en_reg_out_15_8;
    assign obs[2] = en_reg_pwm_7_0;
    assign obs[3] = en_reg_pwm_15_8;
    assign obs[4] = pwm_duty_cycle;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic send_bits(input logic [17:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            spi_bus.copi = bits[i];
            repeat (HALF) @(negedge clk);
            spi_bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_bus.sclk = 1'b0;
        end
    endtask

    // Called on a falling clk edge; returns `gap` clk periods after ncs rises.
    task automatic spi_frame(input logic [17:0] bits, input int nbits, input int gap);
        spi_bus.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(bits, nbits - 1, 0);
        repeat (HALF) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        spi_bus.ncs  = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL reset reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset frame_err: got %b expected 0", frame_err);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single_write();
        int e0;
        e0 = err_pulses;
        exp_r[0] = 8'h55;
        spi_frame(18'h08055, 16, 4);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL single_write reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("FAIL single_write frame_err pulses: got %0d expected %0d", err_pulses, e0);
        end
    endtask

    task automatic test_two_writes();
        spi_frame(18'h084C0, 16, 6);
        spi_frame(18'h083FF, 16, 6);
        exp_r[4] = 8'hC0;
        exp_r[3] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL two_writes reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_bad_length();
        int e0;
        e0 = err_pulses;
        spi_frame(18'h00800, 12, 6);
        checks++;
        if (err_pulses !== e0 + 1) begin
            errors++;
            $display("FAIL short_frame pulses: got %0d expected %0d", err_pulses, e0 + 1);
        end
        spi_frame(18'h20155, 18, 6);
        checks++;
        if (err_pulses !== e0 + 2) begin
            errors++;
            $display("FAIL long_frame pulses: got %0d expected %0d", err_pulses, e0 + 2);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL bad_length reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_ignored();
        int e0;
        e0 = err_pulses;
        spi_frame(18'h08A12, 16, 6);
        spi_frame(18'h00077, 16, 6);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL ignored reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("FAIL ignored frame_err pulses: got %0d expected %0d", err_pulses, e0);
        end
    endtask

    task automatic test_back_to_back();
        spi_frame(18'h08001, 16, 4);
        spi_frame(18'h08102, 16, 4);
        exp_r[0] = 8'h01;
        exp_r[1] = 8'h02;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL back_to_back reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_commit_overlap();
        int e0;
        e0 = err_pulses;
        spi_frame(18'h08203, 16, 1);
        spi_frame(18'h08304, 16, 6);
        exp_r[2] = 8'h03;
        exp_r[3] = 8'h04;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL commit_overlap reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("FAIL commit_overlap frame_err pulses: got %0d expected %0d", err_pulses, e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        spi_bus.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(18'h081AA, 15, 7);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL mid_reset hold reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
        rst = 1'b0;
        e0 = err_pulses;
        send_bits(18'h081AA, 6, 0);
        repeat (HALF) @(negedge clk);
        spi_bus.ncs = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL mid_reset remainder reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("FAIL mid_reset frame_err pulses: got %0d expected %0d", err_pulses, e0);
        end
        repeat (4) @(negedge clk);
        spi_frame(18'h081AA, 16, 4);
        exp_r[1] = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL mid_reset rewrite reg%0d: got %h expected %h", i, obs[i], exp_r[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_two_writes();
        test_bad_length();
        test_ignored();
        test_back_to_back();
        test_commit_overlap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
